// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// all-off output codes and the hex-to-segment decode table.
package seg_display_pkg;

    // Register offsets decoded from the low address bits.
    localparam logic [2:0] ADDR_DATA_LO = 3'b000;
    localparam logic [2:0] ADDR_DATA_HI = 3'b010;
    localparam logic [2:0] ADDR_CTRL    = 3'b100;

    // Active-low outputs, so all ones means everything dark.
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    // Active-low segment patterns, bit0=a .. bit6=g (decimal point excluded).
    localparam logic [6:0] HEX_SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg_display_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg = HEX_SEG7[hex];
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment display controller.
// Bus registers hold digit data, enable and decimal-point masks; a free-running
// scan walks the common lines, blanking the start of each slot to hide ghosting.
// All state advances on the falling clock edge.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        displayCtrl,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [2:0]  address,
    input  logic [15:0] write_data_input,
    output logic [15:0] read_data_output,
    output logic [7:0]  seg_out,
    output logic [7:0]  digit_sel
);

    localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYCLES);

    logic [15:0] data_lo;
    logic [15:0] data_hi;
    logic [7:0]  en_mask;
    logic [7:0]  dp_mask;

    logic [15:0] cnt;
    logic [2:0]  idx;

    logic        bus_write;
    logic        bus_read;
    logic [15:0] read_mux;
    logic [31:0] digits;
    logic [3:0]  nibble;
    logic [6:0]  seg7;
    logic        lit;

    assign bus_write = displayCtrl && write_enable;
    assign bus_read  = displayCtrl && read_enable;

    // Register-file write port; unmapped offsets are ignored.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            data_lo <= '0;
            data_hi <= '0;
            en_mask <= '1;
            dp_mask <= '0;
        end else if (bus_write) begin
            case (address)
                ADDR_DATA_LO: data_lo <= write_data_input;
                ADDR_DATA_HI: data_hi <= write_data_input;
                ADDR_CTRL: begin
                    en_mask <= write_data_input[7:0];
                    dp_mask <= write_data_input[15:8];
                end
                default: ;
            endcase
        end
    end

    // Read mux of the current register contents; unmapped offsets read zero.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA_LO: read_mux = data_lo;
            ADDR_DATA_HI: read_mux = data_hi;
            ADDR_CTRL:    read_mux = {dp_mask, en_mask};
            default:      read_mux = '0;
        endcase
    end

    // Registered read data; samples pre-write contents on a same-edge read/write.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            read_data_output <= '0;
        end else if (bus_read) begin
            read_data_output <= read_mux;
        end else begin
            read_data_output <= '0;
        end
    end

    // Free-running slot counter and digit index, independent of bus traffic.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Select the nibble for the digit being scanned and decide if it is lit.
    always_comb begin
        digits = {data_hi, data_lo};
        nibble = digits[{idx, 2'b00} +: 4];
        lit    = (cnt >= BLANK_END) && en_mask[idx];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (seg7)
    );

    // Output register: one digit line low at most, all dark while blanking.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            seg_out   <= SEG_OFF;
            digit_sel <= DIGIT_OFF;
        end else if (lit) begin
            seg_out   <= {~dp_mask[idx], seg7};
            digit_sel <= ~(8'b1 << idx);
        end else begin
            seg_out   <= SEG_OFF;
            digit_sel <= DIGIT_OFF;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_display_ctrl;

    logic        clock;
    logic        reset;
    logic        displayCtrl;
    logic        write_enable;
    logic        read_enable;
    logic [2:0]  address;
    logic [15:0] write_data_input;
    logic [15:0] read_data_output;
    logic [7:0]  seg_out;
    logic [7:0]  digit_sel;

    int errors = 0;
    int checks = 0;
    // Edges since the last reset release; before edge k+1 the DUT holds cnt=k%8, idx=(k/8)%8.
    int k = 0;

    // Hand-derived expectations for digits 0..7.
    logic [7:0] sel_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_mix [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_display_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .displayCtrl      (displayCtrl),
        .write_enable     (write_enable),
        .read_enable      (read_enable),
        .address          (address),
        .write_data_input (write_data_input),
        .read_data_output (read_data_output),
        .seg_out          (seg_out),
        .digit_sel        (digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
        k++;
    endtask

    // Advance until the DUT sits at digit d, cycle c, then take that edge.
    task automatic goto_slot(input int d, input int c);
        for (int n = 0; n < 64 && (k % 64) != (8 * d + c); n++) tick();
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] v, input logic cs);
        displayCtrl = cs; write_enable = 1'b1; address = a; write_data_input = v;
        tick();
        displayCtrl = 1'b0; write_enable = 1'b0; address = 3'b000; write_data_input = 16'h0000;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic cs);
        displayCtrl = cs; read_enable = 1'b1; address = a;
        tick();
        displayCtrl = 1'b0; read_enable = 1'b0; address = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1; displayCtrl = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        address = 3'b000; write_data_input = 16'h0000;
        #23;
        checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=FF", seg_out); end
        checks++; if (digit_sel !== 8'hFF) begin errors++; $display("FAIL reset_sel got=%h exp=FF", digit_sel); end
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL reset_rd got=%h exp=0000", read_data_output); end
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_scan_default();
        logic [7:0] es, eg;
        for (int e = 1; e <= 72; e++) begin
            int c, i;
            tick();
            c = (e - 1) % 8;
            i = ((e - 1) / 8) % 8;
            es = (c < 2) ? 8'hFF : sel_exp[i];
            eg = (c < 2) ? 8'hFF : 8'hC0;
            checks++; if (digit_sel !== es) begin errors++; $display("FAIL scan_sel edge=%0d got=%h exp=%h", e, digit_sel, es); end
            checks++; if (seg_out !== eg) begin errors++; $display("FAIL scan_seg edge=%0d got=%h exp=%h", e, seg_out, eg); end
        end
    endtask

    task automatic test_digits();
        bus_write(3'b000, 16'h3210, 1'b1);
        bus_write(3'b010, 16'hFEDC, 1'b1);
        bus_write(3'b100, 16'h00FF, 1'b1);
        for (int d = 0; d < 8; d++) begin
            goto_slot(d, 1);
            checks++; if (digit_sel !== 8'hFF || seg_out !== 8'hFF) begin
                errors++; $display("FAIL blank d=%0d got=%h/%h exp=FF/FF", d, digit_sel, seg_out); end
            tick();
            checks++; if (digit_sel !== sel_exp[d]) begin errors++; $display("FAIL digit_sel d=%0d got=%h exp=%h", d, digit_sel, sel_exp[d]); end
            checks++; if (seg_out !== seg_mix[d]) begin errors++; $display("FAIL digit_seg d=%0d got=%h exp=%h", d, seg_out, seg_mix[d]); end
        end
    endtask

    task automatic test_masks();
        bus_write(3'b100, 16'h01F0, 1'b1);
        for (int d = 0; d < 4; d++) begin
            goto_slot(d, 4);
            checks++; if (digit_sel !== 8'hFF || seg_out !== 8'hFF) begin
                errors++; $display("FAIL disabled d=%0d got=%h/%h exp=FF/FF", d, digit_sel, seg_out); end
        end
        goto_slot(4, 3);
        checks++; if (digit_sel !== 8'hEF || seg_out !== 8'hC6) begin
            errors++; $display("FAIL dp_off got=%h/%h exp=EF/C6", digit_sel, seg_out); end
        // Mid-slot data update on the lit digit 5.
        goto_slot(5, 3);
        checks++; if (digit_sel !== 8'hDF || seg_out !== 8'hA1) begin
            errors++; $display("FAIL midslot_pre got=%h/%h exp=DF/A1", digit_sel, seg_out); end
        bus_write(3'b010, 16'hFE0C, 1'b1);
        checks++; if (seg_out !== 8'hA1) begin errors++; $display("FAIL midslot_same_edge got=%h exp=A1", seg_out); end
        tick();
        checks++; if (digit_sel !== 8'hDF || seg_out !== 8'hC0) begin
            errors++; $display("FAIL midslot_next got=%h/%h exp=DF/C0", digit_sel, seg_out); end
        bus_write(3'b010, 16'hFEDC, 1'b1);
        bus_write(3'b100, 16'h10F0, 1'b1);
        goto_slot(4, 3);
        checks++; if (digit_sel !== 8'hEF || seg_out !== 8'h46) begin
            errors++; $display("FAIL dp_on got=%h/%h exp=EF/46", digit_sel, seg_out); end
    endtask

    task automatic test_reads();
        bus_read(3'b000, 1'b1);
        checks++; if (read_data_output !== 16'h3210) begin errors++; $display("FAIL rd_lo got=%h exp=3210", read_data_output); end
        tick();
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL rd_idle got=%h exp=0000", read_data_output); end
        bus_read(3'b010, 1'b1);
        checks++; if (read_data_output !== 16'hFEDC) begin errors++; $display("FAIL rd_hi got=%h exp=FEDC", read_data_output); end
        bus_read(3'b100, 1'b1);
        checks++; if (read_data_output !== 16'h10F0) begin errors++; $display("FAIL rd_ctrl got=%h exp=10F0", read_data_output); end
        bus_read(3'b110, 1'b1);
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL rd_unmapped got=%h exp=0000", read_data_output); end
        bus_read(3'b000, 1'b0);
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL rd_nocs got=%h exp=0000", read_data_output); end
        bus_write(3'b000, 16'hDEAD, 1'b0);
        bus_write(3'b110, 16'hBEEF, 1'b1);
        bus_read(3'b000, 1'b1);
        checks++; if (read_data_output !== 16'h3210) begin errors++; $display("FAIL wr_nocs got=%h exp=3210", read_data_output); end
        bus_read(3'b100, 1'b1);
        checks++; if (read_data_output !== 16'h10F0) begin errors++; $display("FAIL wr_unmapped got=%h exp=10F0", read_data_output); end
    endtask

    task automatic test_back_to_back();
        displayCtrl = 1'b1; write_enable = 1'b1; read_enable = 1'b1;
        address = 3'b000; write_data_input = 16'h1111;
        tick();
        displayCtrl = 1'b0; write_enable = 1'b0; read_enable = 1'b0; write_data_input = 16'h0000;
        checks++; if (read_data_output !== 16'h3210) begin errors++; $display("FAIL rw_old got=%h exp=3210", read_data_output); end
        bus_read(3'b000, 1'b1);
        checks++; if (read_data_output !== 16'h1111) begin errors++; $display("FAIL rw_new got=%h exp=1111", read_data_output); end
    endtask

    task automatic test_reset_mid_scan();
        goto_slot(5, 3);
        checks++; if (digit_sel !== 8'hDF || seg_out !== 8'hA1) begin
            errors++; $display("FAIL prereset got=%h/%h exp=DF/A1", digit_sel, seg_out); end
        #2 reset = 1'b1;
        #1;
        checks++; if (digit_sel !== 8'hFF || seg_out !== 8'hFF) begin
            errors++; $display("FAIL async_reset got=%h/%h exp=FF/FF", digit_sel, seg_out); end
        tick(); tick();
        checks++; if (digit_sel !== 8'hFF || seg_out !== 8'hFF) begin
            errors++; $display("FAIL reset_hold got=%h/%h exp=FF/FF", digit_sel, seg_out); end
        #2 reset = 1'b0;
        k = 0;
        goto_slot(0, 1);
        checks++; if (digit_sel !== 8'hFF || seg_out !== 8'hFF) begin
            errors++; $display("FAIL restart_blank got=%h/%h exp=FF/FF", digit_sel, seg_out); end
        tick();
        checks++; if (digit_sel !== 8'hFE || seg_out !== 8'hC0) begin
            errors++; $display("FAIL restart_d0 got=%h/%h exp=FE/C0", digit_sel, seg_out); end
        for (int d = 1; d < 8; d++) begin
            goto_slot(d, 2);
            checks++; if (digit_sel !== sel_exp[d] || seg_out !== 8'hC0) begin
                errors++; $display("FAIL restart d=%0d got=%h/%h exp=%h/C0", d, digit_sel, seg_out, sel_exp[d]); end
        end
        bus_read(3'b100, 1'b1);
        checks++; if (read_data_output !== 16'h00FF) begin errors++; $display("FAIL reset_ctrl got=%h exp=00FF", read_data_output); end
        bus_read(3'b000, 1'b1);
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL reset_lo got=%h exp=0000", read_data_output); end
        bus_read(3'b010, 1'b1);
        checks++; if (read_data_output !== 16'h0000) begin errors++; $display("FAIL reset_hi got=%h exp=0000", read_data_output); end
    endtask

    initial begin
        test_reset();
        test_scan_default();
        test_digits();
        test_masks();
        test_reads();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
